// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache controller.
package dcache_pkg;

  localparam int OFF_W  = 5;
  localparam int WORD_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WB_REQ    = 2'd1,
    FILL_REQ  = 2'd2,
    FILL_DONE = 2'd3
  } stateT;

  function automatic int idxWidth(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tagWidth(input int lines);
    return 32 - $clog2(lines) - OFF_W;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag and line-data storage: asynchronous read by index, synchronous line or word write.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256,
  parameter int IDX       = idxWidth(LINES),
  parameter int TAG_W     = tagWidth(LINES)
) (
  input  logic                 clk_i,
  input  logic [IDX-1:0]       idx,
  output logic [TAG_W-1:0]     rdTag,
  output logic [LINE_BITS-1:0] rdLine,
  input  logic                 lineWe,
  input  logic [TAG_W-1:0]     wrTag,
  input  logic [LINE_BITS-1:0] wrLine,
  input  logic                 wordWe,
  input  logic [WORD_W-1:0]    wrWordSel,
  input  logic [31:0]          wrWord
);

  logic [TAG_W-1:0]     tagArr  [LINES];
  logic [LINE_BITS-1:0] dataArr [LINES];

  assign rdTag  = tagArr[idx];
  assign rdLine = dataArr[idx];

  // Contents are deliberately not reset; validity lives in the controller.
  always_ff @(posedge clk_i) begin
    if (lineWe) begin
      dataArr[idx] <= wrLine;
      tagArr[idx]  <= wrTag;
    end else if (wordWe) begin
      dataArr[idx][{wrWordSel, 5'd0} +: 32] <= wrWord;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: hit/miss, victim write-back and refill.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_BITS-1:0] mem_rdata_i
);

  localparam int IDX   = idxWidth(LINES);
  localparam int TAG_W = tagWidth(LINES);

  stateT                state;
  logic [LINES-1:0]     valid;
  logic [LINES-1:0]     dirty;
  logic [IDX-1:0]       idx;
  logic [TAG_W-1:0]     tag;
  logic [WORD_W-1:0]    word;
  logic [TAG_W-1:0]     rdTag;
  logic [LINE_BITS-1:0] rdLine;
  logic                 hit;
  logic                 lineWe;
  logic                 wordWe;
  logic                 unusedBits;

  assign idx        = addr_i[OFF_W +: IDX];
  assign tag        = addr_i[31 -: TAG_W];
  assign word       = addr_i[4:2];
  assign unusedBits = ^addr_i[1:0];

  assign hit     = valid[idx] & (rdTag == tag);
  assign rdata_o = hit ? rdLine[{word, 5'd0} +: 32] : 32'd0;
  // Reset gates stall combinationally so the pipeline is released the instant reset asserts.
  assign stall_o = rst_i & start_i & req_i & ~((state == IDLE) & hit);

  assign wordWe = start_i & req_i & we_i & hit & (state == IDLE);
  assign lineWe = start_i & mem_ack_i & (state == FILL_REQ);

  dcache_sram #(
    .LINES    (LINES),
    .LINE_BITS(LINE_BITS),
    .IDX      (IDX),
    .TAG_W    (TAG_W)
  ) uSram (
    .clk_i    (clk_i),
    .idx      (idx),
    .rdTag    (rdTag),
    .rdLine   (rdLine),
    .lineWe   (lineWe),
    .wrTag    (tag),
    .wrLine   (mem_rdata_i),
    .wordWe   (wordWe),
    .wrWordSel(word),
    .wrWord   (wdata_i)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      valid       <= '0;
      dirty       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (start_i) begin
      case (state)
        IDLE: begin
          if (req_i) begin
            if (hit) begin
              if (we_i) dirty[idx] <= 1'b1;
            end else if (valid[idx] & dirty[idx]) begin
              state       <= WB_REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= {rdTag, idx, {OFF_W{1'b0}}};
              mem_wdata_o <= rdLine;
            end else begin
              state      <= FILL_REQ;
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_addr_o <= {addr_i[31:OFF_W], {OFF_W{1'b0}}};
            end
          end
        end
        WB_REQ: begin
          if (mem_ack_i) begin
            state      <= FILL_REQ;
            mem_we_o   <= 1'b0;
            mem_addr_o <= {addr_i[31:OFF_W], {OFF_W{1'b0}}};
          end
        end
        FILL_REQ: begin
          if (mem_ack_i) begin
            state      <= FILL_DONE;
            mem_req_o  <= 1'b0;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
          end
        end
        FILL_DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios then random traffic checked against a transparent-memory model.
module tb_dcache_ctrl;

  localparam int LINES = 32;
  localparam int LB    = 256;

  logic          clk_i = 1'b0;
  logic          rst_i, start_i, req_i, we_i, mem_ack_i;
  logic [31:0]   addr_i, wdata_i, rdata_o, mem_addr_o;
  logic          stall_o, mem_req_o, mem_we_o;
  logic [LB-1:0] mem_wdata_o, mem_rdata_i;

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(.LINES(LINES), .LINE_BITS(LB)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;

  // Architectural word values (stores) and the backing memory's line contents.
  logic [31:0] refMem  [logic [31:0]];
  logic [LB-1:0] backMem [logic [31:0]];
  bit          mValid [LINES];
  bit          mDirty [LINES];
  logic [21:0] mTag   [LINES];

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [LB-1:0] backLine(input logic [31:0] la);
    logic [LB-1:0] l;
    if (backMem.exists(la)) return backMem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = initWord(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [31:0] archWord(input logic [31:0] a);
    logic [LB-1:0] l;
    if (refMem.exists(a)) return refMem[a];
    l = backLine({a[31:5], 5'b0});
    return l[{a[4:2], 5'd0} +: 32];
  endfunction

  function automatic logic [LB-1:0] archLine(input logic [31:0] la);
    logic [LB-1:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = archWord(la + 32'(w * 4));
    return l;
  endfunction

  // Reset discards dirty data: the architectural view falls back to memory.
  task automatic resetModel();
    logic [31:0]   la;
    logic [LB-1:0] lb;
    for (int i = 0; i < LINES; i++) begin
      if (mValid[i] && mDirty[i]) begin
        la = {mTag[i], 5'(i), 5'b0};
        lb = backLine(la);
        for (int w = 0; w < 8; w++) refMem[la + 32'(w * 4)] = lb[w*32 +: 32];
      end
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
    end
  endtask

  task automatic memPhase(input bit expWe, input logic [31:0] expAddr, input logic [LB-1:0] expData,
                          input int dly, input int pause);
    @(negedge clk_i);
    chk("memReq", 256'({mem_req_o, mem_we_o, mem_addr_o}), 256'({1'b1, expWe, expAddr}));
    if (expWe) chk("wbData", mem_wdata_o, expData);
    if (pause > 0) begin
      start_i = 1'b0;
      #1 chk("pauseStall", 256'(stall_o), 256'(1'b0));
      repeat (pause) begin
        @(negedge clk_i);
        chk("pauseHold", 256'({stall_o, mem_req_o, mem_we_o, mem_addr_o}), 256'({1'b0, 1'b1, expWe, expAddr}));
      end
      start_i = 1'b1;
    end
    repeat (dly) begin
      @(negedge clk_i);
      chk("hold", 256'({stall_o, mem_req_o, mem_we_o, mem_addr_o}), 256'({1'b1, 1'b1, expWe, expAddr}));
      if (expWe) chk("holdData", mem_wdata_o, expData);
    end
    if (expWe) backMem[expAddr] = mem_wdata_o;
    mem_rdata_i = backLine(expAddr);
    mem_ack_i   = 1'b1;
    @(posedge clk_i);
    #1 mem_ack_i = 1'b0;
  endtask

  task automatic doAccess(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input int dly, input int pause);
    logic [4:0]  ix;
    logic [21:0] tg;
    logic [31:0] va;
    bit          hitExp;
    ix     = a[9:5];
    tg     = a[31:10];
    hitExp = mValid[ix] && (mTag[ix] == tg);
    @(posedge clk_i);
    #1;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = a;
    wdata_i = wd;
    @(negedge clk_i);
    chk("missStall", 256'(stall_o), 256'(!hitExp));
    if (!hitExp) begin
      if (mValid[ix] && mDirty[ix]) begin
        va = {mTag[ix], ix, 5'b0};
        memPhase(1'b1, va, archLine(va), dly, pause);
      end
      memPhase(1'b0, {a[31:5], 5'b0}, '0, dly, pause);
      @(negedge clk_i);
      chk("fillDone", 256'({stall_o, mem_req_o}), 256'(2'b10));
      @(negedge clk_i);
      chk("resume", 256'(stall_o), 256'(1'b0));
      mValid[ix] = 1'b1;
      mTag[ix]   = tg;
      mDirty[ix] = 1'b0;
    end
    if (!we) chk("load", 256'(rdata_o), 256'(archWord(a)));
    else begin
      refMem[a]  = wd;
      mDirty[ix] = 1'b1;
    end
    @(posedge clk_i);
    #1 req_i = 1'b0;
  endtask

  task automatic spuriousAck();
    @(negedge clk_i);
    mem_rdata_i = {8{$urandom}};
    mem_ack_i   = 1'b1;
    @(posedge clk_i);
    #1 mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("spurious", 256'({stall_o, mem_req_o}), 256'(2'b00));
  endtask

  initial begin
    logic [LB-1:0] l;
    logic [31:0]   a;
    rst_i = 1'b0; start_i = 1'b1; req_i = 1'b0; we_i = 1'b0;
    addr_i = '0; wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < LINES; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
    end
    l = backLine(32'h40);
    l[95:64] = 32'hDEAD_BEEF;
    backMem[32'h40] = l;

    #3 req_i = 1'b1; addr_i = 32'h48;
    #1 chk("rstOut", 256'({stall_o, mem_req_o, mem_we_o, mem_addr_o, rdata_o}), '0);
    chk("rstWdata", mem_wdata_o, '0);
    req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;

    doAccess(1'b0, 32'h48, 32'h0, 0, 0);
    doAccess(1'b1, 32'h40, 32'h1234_5678, 0, 0);
    doAccess(1'b0, 32'h40, 32'h0, 0, 0);
    doAccess(1'b0, 32'h440, 32'h0, 1, 0);
    doAccess(1'b0, 32'h848, 32'h0, 20, 0);
    spuriousAck();
    doAccess(1'b0, 32'h84C, 32'h0, 0, 0);

    // Miss presented while disabled: nothing may start.
    start_i = 1'b0;
    @(posedge clk_i);
    #1 req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1040;
    repeat (3) begin
      @(negedge clk_i);
      chk("frozen", 256'({stall_o, mem_req_o}), 256'(2'b00));
    end
    req_i = 1'b0;
    start_i = 1'b1;

    doAccess(1'b1, 32'h60, 32'hA5A5_0001, 2, 3);
    doAccess(1'b1, 32'h40, 32'h1234_5678, 0, 0);

    // Reset in the middle of a refill.
    @(posedge clk_i);
    #1 req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4A0;
    @(negedge clk_i);
    chk("rstMissStall", 256'(stall_o), 256'(1'b1));
    @(negedge clk_i);
    chk("rstFillReq", 256'({mem_req_o, mem_we_o, mem_addr_o}), 256'({1'b1, 1'b0, 32'h4A0}));
    #2 rst_i = 1'b0;
    #1 chk("rstAsync", 256'({mem_req_o, stall_o, mem_addr_o}), '0);
    req_i = 1'b0;
    resetModel();
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    doAccess(1'b0, 32'h40, 32'h0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 5)
        | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 19) == 0) spuriousAck();
      doAccess(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)),
               ($urandom_range(0, 15) == 0) ? 2 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
